nibble_serial_add_ctrl: RTL and testbench

Sequencer that reuses one 4-bit adder (inputs a, b; outputs sum, cout; no carry-in) to perform a multi-nibble add, one nibble per step, LSB first. The adder has no carry-in, so each nibble takes two adder passes: a+b, then the result plus the stored carry. The adder is instantiated outside this block and connected through the add_* ports. Upstream logic supplies operands with a start/busy/done handshake.

---
 rtl/nibble_serial_add_ctrl.sv | 140 ++++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Sequences one external 4-bit adder (no carry-in) over NIBBLES nibbles, LSB first, two passes per nibble.
// Latency: done pulses 2*NIBBLES cycles after start acceptance; busy covers PASS1/PASS2/DONE.
// Backpressure: none; start is sampled only in IDLE, and start while busy is dropped (no queueing).
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum_out,
    output logic                 carry_out,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout
);

    localparam int W = 4 * NIBBLES;
    localparam logic [2:0] LAST_IDX = 3'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t       state;
    logic [2:0]   idx;
    logic         carry;
    logic         c1;
    logic [3:0]   tmp;
    logic [W-1:0] a_reg;
    logic [W-1:0] b_reg;
    logic [W-1:0] partial;

    logic [W-1:0] a_sh;
    logic [W-1:0] b_sh;
    logic [W-1:0] partial_nxt;
    logic         carry_nxt;

    // Operand nibble select: shift the current nibble down to bit 0.
    assign a_sh = a_reg >> {idx, 2'b00};
    assign b_sh = b_reg >> {idx, 2'b00};

    // The two passes never both carry (tmp+1 overflows only when tmp=F, i.e. c1=0), so OR is exact.
    assign carry_nxt = c1 | add_cout;

    // Partial result with the current pass-2 nibble merged in; feeds both partial and sum_out.
    always_comb begin
        partial_nxt = partial;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == 3'(i)) begin
                partial_nxt[4*i +: 4] = add_sum;
            end
        end
    end

    // Adder operand mux: driven only from state and registers, never from the adder outputs.
    always_comb begin
        add_a = 4'h0;
        add_b = 4'h0;
        case (state)
            PASS1: begin
                add_a = a_sh[3:0];
                add_b = b_sh[3:0];
            end
            PASS2: begin
                add_a = tmp;
                add_b = {3'b000, carry};
            end
            default: begin
                add_a = 4'h0;
                add_b = 4'h0;
            end
        endcase
    end

    // Sequencer FSM with registered busy/done/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 3'd0;
            carry     <= 1'b0;
            c1        <= 1'b0;
            tmp       <= 4'h0;
            a_reg     <= '0;
            b_reg     <= '0;
            partial   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum_out   <= '0;
            carry_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= op_a;
                        b_reg <= op_b;
                        idx   <= 3'd0;
                        carry <= 1'b0;
                        busy  <= 1'b1;
                        state <= PASS1;
                    end
                end
                PASS1: begin
                    tmp   <= add_sum;
                    c1    <= add_cout;
                    state <= PASS2;
                end
                PASS2: begin
                    partial <= partial_nxt;
                    carry   <= carry_nxt;
                    if (idx == LAST_IDX) begin
                        sum_out   <= partial_nxt;
                        carry_out <= carry_nxt;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx   <= idx + 3'd1;
                        state <= PASS1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: behavioural 4-bit adder, directed operands, scoreboard on done.
// Expected results are pushed at start acceptance; a negedge monitor pops and compares on done.
// Busy-run length, done latency and the two-pass carry rule are also checked by the monitor.
module tb_nibble_serial_add_ctrl;

    localparam int N = 4;
    localparam int LAT = 2 * N;

    typedef struct {
        logic [15:0] sum;
        logic        cy;
        int          acc_cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        busy;
    logic        done;
    logic [15:0] sum_out;
    logic        carry_out;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic [3:0]  add_sum;
    logic        add_cout;

    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    int   busy_run = 0;
    bit   run_saw_done = 0;
    exp_t q[$];

    nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .sum_out   (sum_out),
        .carry_out (carry_out),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    // External adder model: no carry-in.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard on done, busy-run length, carry rule in PASS2.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
            run_saw_done = 0;
        end else begin
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("sum_out", sum_out, e.sum);
                    check("carry_out", carry_out, e.cy);
                    check("done_latency", cyc - e.acc_cyc, LAT);
                    check("busy_with_done", busy, 1);
                end
                run_saw_done = 1;
            end
            if (busy) begin
                busy_run++;
            end else begin
                if (busy_run > 0 && run_saw_done) check("busy_cycles", busy_run, LAT + 1);
                busy_run = 0;
                run_saw_done = 0;
            end
            if (dut.state == 2'd2) check("carry_rule", dut.c1 & add_cout, 0);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) check("wait_idle_timeout", 1, 0);
    endtask

    task automatic wait_accept();
        int n = 0;
        while (!busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!busy) check("wait_accept_timeout", 1, 0);
    endtask

    task automatic push_exp(input logic [15:0] s, input logic c);
        exp_t e;
        e.sum = s;
        e.cy = c;
        e.acc_cyc = cyc;
        q.push_back(e);
    endtask

    // One pulsed add; operands are scrambled right after acceptance.
    task automatic add_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] es, input logic ec);
        wait_idle();
        op_a = a;
        op_b = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("accept_busy", busy, 1);
        push_exp(es, ec);
        op_a = ~a;
        op_b = a ^ b;
        wait_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op_a = 16'h0;
        op_b = 16'h0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum_out, 16'h0);
        check("rst_carry", carry_out, 0);
        check("rst_add_a", add_a, 4'h0);
        check("rst_add_b", add_b, 4'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        add_op(16'h1234, 16'h4321, 16'h5555, 1'b0);
        check("idle_add_a", add_a, 4'h0);
        check("idle_add_b", add_b, 4'h0);
        add_op(16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        add_op(16'h8000, 16'h8000, 16'h0000, 1'b1);
        add_op(16'h0F0F, 16'h0101, 16'h1010, 1'b0);

        // Second start while busy is dropped.
        wait_idle();
        op_a = 16'h0001;
        op_b = 16'h0002;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push_exp(16'h0003, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        op_a = 16'hAAAA;
        op_b = 16'h5555;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("dropped_busy", busy, 0);
        check("dropped_sum_hold", sum_out, 16'h0003);

        // Reset during the third PASS1 aborts with no done pulse.
        op_a = 16'h1111;
        op_b = 16'h2222;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_in_pass1", dut.state, 2'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum_out, 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        add_op(16'h0005, 16'h0005, 16'h000A, 1'b0);

        // Start held high across two adds; operands switched mid-first-op.
        wait_idle();
        op_a = 16'h0102;
        op_b = 16'h0304;
        start = 1'b1;
        wait_accept();
        push_exp(16'h0406, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        op_a = 16'hF000;
        op_b = 16'h1000;
        wait_idle();
        wait_accept();
        push_exp(16'h0000, 1'b1);
        start = 1'b0;
        op_a = 16'h7777;
        op_b = 16'h7777;
        wait_idle();

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
